// File: rtl/dtim_pipe.sv
// dtim_pipe: parametrised data tightly-integrated memory for the LSU.
// Single-port byte-maskable RAM with a registered read, an optional second
// output register (READ_LAT=2), read-first read-during-write behaviour and a
// DTIMBusy output.
// Optional feature macro: DTIM_ZEROINIT_EN -- when defined, a reset-time sweep
// writes zero to every word and DTIMBusy is held high for DEPTH cycles.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_INIT    | zero-init sweep in progress, external requests ignored
// ST_READY   | normal operation
module dtim_pipe #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 1024,
  parameter int ADR_BITS = 34,
  parameter int READ_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  FlushW,
  input  logic                  ce,
  input  logic [1:0]            MemRWM,
  input  logic [ADR_BITS-1:0]   DTIMAdr,
  input  logic [WIDTH-1:0]      WriteDataM,
  input  logic [WIDTH/8-1:0]    ByteMaskM,
  output logic [WIDTH-1:0]      ReadDataWordM,
  output logic                  DTIMBusy
);

  localparam int NBYTES = WIDTH / 8;
  localparam int OFFSET = $clog2(NBYTES);
  localparam int IDX    = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX-1:0]   idx;
  logic             we;
  logic             rd_en;
  logic             init_we;
  logic [IDX-1:0]   init_idx;
  logic [WIDTH-1:0] rd_q;
  logic [WIDTH-1:0] rd_d;

  // Upper address bits and the read qualifier are intentionally not used here;
  // the read qualifier only matters to downstream subword logic.
  logic unused_ok;
  assign unused_ok = ^{DTIMAdr, MemRWM[1]};

  assign idx = DTIMAdr[IDX+OFFSET-1:OFFSET];

`ifdef DTIM_ZEROINIT_EN
  localparam logic ST_INIT  = 1'b0;
  localparam logic ST_READY = 1'b1;

  logic           state_q, state_d;
  logic [IDX-1:0] cnt_q, cnt_d;

  // Sweep sequencing: advance the word counter every cycle while in INIT,
  // leave INIT once the last word has been written.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + IDX'(1);
      if (cnt_q == IDX'(DEPTH - 1)) begin
        state_d = ST_READY;
      end
    end
  end

  // Sweep state registers; any reset restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign DTIMBusy = (state_q == ST_INIT);
  // The sweep is independent of ce; it is held off only while reset is high.
  assign init_we  = (state_q == ST_INIT) & ~reset;
  assign init_idx = cnt_q;
`else
  assign DTIMBusy = 1'b0;
  assign init_we  = 1'b0;
  assign init_idx = '0;
`endif

  assign we    = MemRWM[0] & ~FlushW & ce & ~DTIMBusy & ~reset;
  assign rd_en = ce & ~DTIMBusy;

  // RAM write port: zero-init sweep has priority, otherwise masked byte store.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_idx] <= '0;
    end else if (we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (ByteMaskM[b]) begin
          mem[idx][b*8 +: 8] <= WriteDataM[b*8 +: 8];
        end
      end
    end
  end

  // Read stage sees the pre-write contents, giving read-first behaviour.
  always_comb begin
    rd_d = rd_q;
    if (rd_en) begin
      rd_d = mem[idx];
    end
  end

  // Read register; holds while ce is low or the sweep is running.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] out_q;

      // Extra output stage for timing-critical integrations, frozen by ce.
      always_ff @(posedge clk) begin
        if (reset) begin
          out_q <= '0;
        end else if (ce) begin
          out_q <= rd_q;
        end
      end

      assign ReadDataWordM = out_q;
    end else begin : g_lat1
      assign ReadDataWordM = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_dtim_pipe.sv
// Bench for dtim_pipe: one READ_LAT=1 and one READ_LAT=2 instance driven in
// lockstep, checked against a word-array model with a per-enabled-cycle read
// history (latency L means the word read L enabled cycles ago).
module tb_dtim_pipe;

  localparam int WIDTH    = 64;
  localparam int DEPTH    = 1024;
  localparam int ADR_BITS = 34;
`ifdef DTIM_ZEROINIT_EN
  localparam bit ZI = 1'b1;
`else
  localparam bit ZI = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                FlushW;
  logic                ce;
  logic [1:0]          MemRWM;
  logic [ADR_BITS-1:0] DTIMAdr;
  logic [WIDTH-1:0]    WriteDataM;
  logic [WIDTH/8-1:0]  ByteMaskM;
  logic [WIDTH-1:0]    rd1, rd2;
  logic                busy1, busy2;

  always #5 clk = ~clk;

  dtim_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADR_BITS(ADR_BITS), .READ_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .FlushW(FlushW), .ce(ce), .MemRWM(MemRWM),
    .DTIMAdr(DTIMAdr), .WriteDataM(WriteDataM), .ByteMaskM(ByteMaskM),
    .ReadDataWordM(rd1), .DTIMBusy(busy1)
  );

  dtim_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADR_BITS(ADR_BITS), .READ_LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .FlushW(FlushW), .ce(ce), .MemRWM(MemRWM),
    .DTIMAdr(DTIMAdr), .WriteDataM(WriteDataM), .ByteMaskM(ByteMaskM),
    .ReadDataWordM(rd2), .DTIMBusy(busy2)
  );

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] mem_m [DEPTH];
  logic [WIDTH-1:0] hist[$];
  int               busy_left = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] hist_at(input int k);
    if (k < hist.size()) return hist[k];
    return '0;
  endfunction

  // One clock cycle: drive, update the model at the edge, check after the edge.
  task automatic cyc(input logic c, input logic w, input logic [ADR_BITS-1:0] a,
                     input logic [63:0] d, input logic [7:0] m, input logic f,
                     input logic r);
    int  idx;
    bit  busy_now;
    reset = r; ce = c; MemRWM = {1'b1, w}; DTIMAdr = a;
    WriteDataM = d; ByteMaskM = m; FlushW = f;
    @(posedge clk);
    idx      = int'((a >> 3) % DEPTH);
    busy_now = (busy_left > 0);
    if (r) begin
      hist.delete();
      busy_left = ZI ? DEPTH : 0;
      if (ZI) foreach (mem_m[i]) mem_m[i] = '0;
    end else begin
      if (c && !busy_now) begin
        hist.push_front(mem_m[idx]);
        if (hist.size() > 4) void'(hist.pop_back());
        if (w && !f) begin
          for (int b = 0; b < 8; b++)
            if (m[b]) mem_m[idx][b*8 +: 8] = d[b*8 +: 8];
        end
      end
      if (busy_left > 0) busy_left--;
    end
    #1;
    chk("rd_lat1", rd1, hist_at(0));
    chk("rd_lat2", rd2, hist_at(1));
    chk("busy_lat1", {63'b0, busy1}, {63'b0, busy_left > 0});
    chk("busy_lat2", {63'b0, busy2}, {63'b0, busy_left > 0});
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (busy1 && n < 3000) begin
      cyc(1'b1, 1'b1, ADR_BITS'({$urandom(), $urandom()}), {$urandom(), $urandom()},
          8'hFF, 1'b0, 1'b0);
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [63:0] held;
    logic [ADR_BITS-1:0] a;

    // Reset with a write asserted: outputs clear, write dropped.
    cyc(1'b1, 1'b1, 34'h40, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 1'b1);
    chk("rst_rd1", rd1, 64'h0);
    chk("rst_rd2", rd2, 64'h0);
    chk("rst_busy", {63'b0, busy1}, {63'b0, ZI});
    cyc(1'b1, 1'b0, 34'h0, 64'h0, 8'h00, 1'b0, 1'b1);
    wait_ready(n);

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 1'b1, ADR_BITS'(i * 8), {$urandom(), $urandom()}, 8'hFF, 1'b0, 1'b0);

    // Write then read.
    cyc(1'b1, 1'b1, 34'h40, 64'h1122334455667788, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 34'h40, 64'h0, 8'h00, 1'b0, 1'b0);
    chk("wr_rd_0x40", rd1, 64'h1122334455667788);

    // Partial byte mask.
    cyc(1'b1, 1'b1, 34'h40, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 34'h40, 64'h0, 8'h00, 1'b0, 1'b0);
    chk("byte_mask", rd1, 64'h11223344AAAAAAAA);

    // Empty mask is a no-op.
    cyc(1'b1, 1'b1, 34'h40, 64'h0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 34'h40, 64'h0, 8'h00, 1'b0, 1'b0);
    chk("zero_mask", rd1, 64'h11223344AAAAAAAA);

    // Flushed write leaves the word alone.
    cyc(1'b1, 1'b1, 34'h40, 64'hDEADBEEFDEADBEEF, 8'hFF, 1'b1, 1'b0);
    chk("flush_rd_same", rd1, 64'h11223344AAAAAAAA);
    cyc(1'b1, 1'b0, 34'h40, 64'h0, 8'h00, 1'b0, 1'b0);
    chk("flush_kept", rd1, 64'h11223344AAAAAAAA);

    // Read-first on same-cycle write, new data next cycle.
    cyc(1'b1, 1'b1, 34'h40, 64'h5, 8'hFF, 1'b0, 1'b0);
    chk("rdw_old", rd1, 64'h11223344AAAAAAAA);
    cyc(1'b1, 1'b0, 34'h40, 64'h0, 8'h00, 1'b0, 1'b0);
    chk("rdw_new", rd1, 64'h5);

    // ce stall with the two-stage pipe.
    cyc(1'b1, 1'b1, 34'h8, 64'hCAFEF00D12345678, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 34'h10, 64'h0102030405060708, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 34'h10, 64'h0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 34'h8, 64'h0, 8'h00, 1'b0, 1'b0);
    held = rd2;
    chk("lat2_before", rd2, 64'h0102030405060708);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 34'h10, 64'hFFFF, 8'hFF, 1'b0, 1'b0);
      chk("stall_hold2", rd2, held);
      chk("stall_hold1", rd1, 64'hCAFEF00D12345678);
    end
    cyc(1'b1, 1'b0, 34'h10, 64'h0, 8'h00, 1'b0, 1'b0);
    chk("lat2_data", rd2, 64'hCAFEF00D12345678);

    // Index wraps modulo DEPTH.
    cyc(1'b1, 1'b1, 34'h2000, 64'h9, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 34'h0, 64'h0, 8'h00, 1'b0, 1'b0);
    chk("wrap", rd1, 64'h9);

`ifdef DTIM_ZEROINIT_EN
    // Full sweep after reset; writes during busy are ignored.
    cyc(1'b1, 1'b1, 34'h40, 64'h77, 8'hFF, 1'b0, 1'b1);
    wait_ready(n);
    chk("zi_busy_len", 64'(n), 64'd1024);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, ADR_BITS'({$urandom(), $urandom()}), 64'h0, 8'h00, 1'b0, 1'b0);
      chk("zi_zero", rd1, 64'h0);
    end
    // Reset partway through restarts the sweep.
    cyc(1'b1, 1'b1, 34'h0, 64'h1, 8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 500; i++)
      cyc(1'b1, 1'b1, 34'h8, 64'h3, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 34'h0, 64'h0, 8'h00, 1'b0, 1'b1);
    wait_ready(n);
    chk("zi_restart_len", 64'(n), 64'd1024);
`endif

    // Random traffic, biased toward a few words for read-after-write hits.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0)
        a = ADR_BITS'({$urandom(), $urandom()});
      else
        a = ADR_BITS'($urandom_range(0, 7) * 8) | ADR_BITS'($urandom_range(0, 7) << 13);
      cyc($urandom_range(0, 5) != 0, 1'($urandom_range(0, 1)), a,
          {$urandom(), $urandom()}, 8'($urandom()), $urandom_range(0, 7) == 0,
          $urandom_range(0, 299) == 0);
      if (busy1) wait_ready(n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
